// File: rtl/hsi_m_rx_frame_ctrl_if.sv
// ============================================================================
// Module      : hsi_m_rx_frame_ctrl_if
// Description : Decoder-side byte input and consumer-side frame port of the
//               HSI receive frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hsi_m_rx_frame_ctrl_if;
    logic [7:0] d;
    logic       d_rdy;
    logic       msg_valid;
    logic [2:0] msg_type;
    logic [4:0] msg_len;
    logic [4:0] rd_addr;
    logic [7:0] rd_q;
    logic       msg_ack;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output d, d_rdy, rd_addr, msg_ack,
        input  msg_valid, msg_type, msg_len, rd_q, err, err_code
    );

    modport slave (
        input  d, d_rdy, rd_addr, msg_ack,
        output msg_valid, msg_type, msg_len, rd_q, err, err_code
    );
endinterface

`default_nettype wire

// File: rtl/hsi_m_rx_frame_ctrl.sv
// ============================================================================
// Module      : hsi_m_rx_frame_ctrl
// Description : HSI receive frame delineation, payload buffering, CRC16-CCITT
//               check and hold/ack release of good frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsi_m_rx_frame_ctrl #(
    parameter int BYTE_TIMEOUT = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    hsi_m_rx_frame_ctrl_if.slave   bus
);

    localparam logic [2:0]  c_IDLE    = 3'd0;
    localparam logic [2:0]  c_PAYLOAD = 3'd1;
    localparam logic [2:0]  c_CRC_HI  = 3'd2;
    localparam logic [2:0]  c_CRC_LO  = 3'd3;
    localparam logic [2:0]  c_CHECK   = 3'd4;
    localparam logic [2:0]  c_HOLD    = 3'd5;
    localparam logic [2:0]  c_DISCARD = 3'd6;

    localparam logic [1:0]  c_E_CRC     = 2'd0;
    localparam logic [1:0]  c_E_TIMEOUT = 2'd1;
    localparam logic [1:0]  c_E_TYPE    = 2'd2;
    localparam logic [1:0]  c_E_OVERRUN = 2'd3;

    localparam logic [12:0] c_TO_LAST  = 13'(BYTE_TIMEOUT - 1);
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    logic [2:0]  r_state,    w_state_d;
    logic        r_d_rdy_prev;
    logic [12:0] r_cnt,      w_cnt_d;
    logic [4:0]  r_idx,      w_idx_d;
    logic [15:0] r_crc,      w_crc_d;
    logic [15:0] r_crc_rx,   w_crc_rx_d;
    logic [2:0]  r_type,     w_type_d;
    logic [4:0]  r_len,      w_len_d;
    logic        r_valid,    w_valid_d;
    logic        r_err,      w_err_d;
    logic [1:0]  r_err_code, w_err_code_d;
    logic        r_ovr,      w_ovr_d;
    logic [7:0]  r_rd_q;
    logic [7:0]  r_buf [0:31];

    logic        w_accept;
    logic        w_counting;
    logic        w_to_hit;
    logic        w_type_ok;
    logic        w_wr_en;

    // Byte-wise CRC16-CCITT (poly 0x1021, MSB first).
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    assign w_accept   = bus.d_rdy & ~r_d_rdy_prev;
    assign w_type_ok  = (bus.d[7:5] >= 3'd1) && (bus.d[7:5] <= 3'd5);
    assign w_counting = (r_state == c_PAYLOAD) || (r_state == c_CRC_HI) ||
                        (r_state == c_CRC_LO)  || (r_state == c_DISCARD);
    // An accepted byte always beats an expiring timeout.
    assign w_to_hit   = w_counting && !w_accept && (r_cnt == c_TO_LAST);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = (w_counting && !w_accept) ? r_cnt + 13'd1 : 13'd0;
        w_idx_d      = r_idx;
        w_crc_d      = r_crc;
        w_crc_rx_d   = r_crc_rx;
        w_type_d     = r_type;
        w_len_d      = r_len;
        w_valid_d    = r_valid;
        w_err_d      = 1'b0;
        w_err_code_d = 2'd0;
        w_ovr_d      = r_ovr;
        w_wr_en      = 1'b0;

        if (w_to_hit) begin
            w_cnt_d = 13'd0;
        end

        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_crc_d = c_CRC_INIT;
                    w_idx_d = 5'd0;
                    if (w_type_ok) begin
                        w_type_d  = bus.d[7:5];
                        w_len_d   = bus.d[4:0];
                        w_state_d = (bus.d[4:0] != 5'd0) ? c_PAYLOAD : c_CRC_HI;
                    end else begin
                        w_err_d      = 1'b1;
                        w_err_code_d = c_E_TYPE;
                        w_state_d    = c_DISCARD;
                    end
                end
            end
            c_PAYLOAD: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    w_idx_d = r_idx + 5'd1;
                    w_crc_d = f_crc_byte(r_crc, bus.d);
                    if (r_idx == (r_len - 5'd1)) begin
                        w_state_d = c_CRC_HI;
                    end
                end else if (w_to_hit) begin
                    w_err_d      = 1'b1;
                    w_err_code_d = c_E_TIMEOUT;
                    w_crc_d      = c_CRC_INIT;
                    w_state_d    = c_IDLE;
                end
            end
            c_CRC_HI, c_CRC_LO: begin
                if (w_accept) begin
                    if (r_state == c_CRC_HI) begin
                        w_crc_rx_d[15:8] = bus.d;
                        w_state_d        = c_CRC_LO;
                    end else begin
                        w_crc_rx_d[7:0]  = bus.d;
                        w_state_d        = c_CHECK;
                    end
                end else if (w_to_hit) begin
                    w_err_d      = 1'b1;
                    w_err_code_d = c_E_TIMEOUT;
                    w_crc_d      = c_CRC_INIT;
                    w_state_d    = c_IDLE;
                end
            end
            c_CHECK: begin
                if (r_crc_rx == r_crc) begin
                    w_valid_d = 1'b1;
                    w_state_d = c_HOLD;
                end else begin
                    w_err_d      = 1'b1;
                    w_err_code_d = c_E_CRC;
                    w_state_d    = c_IDLE;
                end
            end
            c_HOLD: begin
                if (w_accept) begin
                    w_err_d      = 1'b1;
                    w_err_code_d = c_E_OVERRUN;
                    w_ovr_d      = 1'b1;
                end
                // After an overrun the line is mid-frame, so resync via DISCARD.
                if (bus.msg_ack) begin
                    w_valid_d = 1'b0;
                    w_ovr_d   = 1'b0;
                    w_state_d = (r_ovr || w_accept) ? c_DISCARD : c_IDLE;
                end
            end
            c_DISCARD: begin
                if (w_to_hit) begin
                    w_state_d = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_d_rdy_prev <= 1'b0;
            r_cnt        <= 13'd0;
            r_idx        <= 5'd0;
            r_crc        <= c_CRC_INIT;
            r_crc_rx     <= 16'd0;
            r_type       <= 3'd0;
            r_len        <= 5'd0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_ovr        <= 1'b0;
            r_rd_q       <= 8'd0;
        end else begin
            r_state      <= w_state_d;
            r_d_rdy_prev <= bus.d_rdy;
            r_cnt        <= w_cnt_d;
            r_idx        <= w_idx_d;
            r_crc        <= w_crc_d;
            r_crc_rx     <= w_crc_rx_d;
            r_type       <= w_type_d;
            r_len        <= w_len_d;
            r_valid      <= w_valid_d;
            r_err        <= w_err_d;
            r_err_code   <= w_err_code_d;
            r_ovr        <= w_ovr_d;
            r_rd_q       <= r_buf[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_idx] <= bus.d;
        end
    end

    assign bus.msg_valid = r_valid;
    assign bus.msg_type  = r_type;
    assign bus.msg_len   = r_len;
    assign bus.rd_q      = r_rd_q;
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;

endmodule

`default_nettype wire

// File: doc/hsi_m_rx_frame_ctrl.md
# hsi_m_rx_frame_ctrl

Receive-side frame controller for the HSI link; the counterpart of the master transmit controller. It takes bytes from the line decoder and delineates frames: a header, 0..31 payload bytes, then a CRC16-CCITT. It buffers the payload, checks the CRC, and releases only good frames to the consumer through a hold/acknowledge interface. Every fault is reported as a one-cycle error pulse.

## Interface
Parameters:
- BYTE_TIMEOUT, 2000: maximum idle clk cycles between bytes inside a frame; 13-bit counter.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- d  in  8  decoded byte from the decoder; valid while d_rdy is high.
- d_rdy  in  1  byte-ready level from the decoder; a rising edge (sampled 1, previous sample 0) accepts one byte.
- msg_valid  out  1  a good frame is held in the buffer.
- msg_type  out  3  header type of the held frame: 1 TM, 2 BTC, 3 SR, 4 DPR, 5 CCW.
- msg_len  out  5  payload length of the held frame.
- rd_addr  in  5  buffer read address.
- rd_q  out  8  buffer data at rd_addr, registered; 1-cycle read latency.
- msg_ack  in  1  consumer release; ignored while msg_valid is 0.
- err  out  1  one-cycle error pulse.
- err_code  out  2  meaningful while err=1: 0 CRC mismatch, 1 inter-byte timeout, 2 bad type, 3 overrun.

## Operation
- Frame format:
  - byte0 is the header: [7:5] type, [4:0] payload length N.
  - Then N payload bytes.
  - Then CRC high byte, then CRC low byte.
- CRC16-CCITT: polynomial 0x1021, init 0xFFFF, MSB-first, no final XOR, computed over the payload only. It is updated byte-wise in one cycle when a payload byte is accepted.
- States:
  - IDLE: an accepted byte is taken as the header.
    - Type 1..5 with N>0: go to PAYLOAD.
    - Type 1..5 with N=0: go to CRC_HI.
    - Type 0, 6 or 7: pulse err with code 2, go to DISCARD.
  - PAYLOAD: write each byte to buffer[idx] and increment idx. After byte N-1 is written, go to CRC_HI.
  - CRC_HI: latch the high CRC byte, go to CRC_LO.
  - CRC_LO: latch the low CRC byte, go to CHECK.
  - CHECK: lasts one cycle.
    - Received CRC equals computed CRC: set msg_valid and go to HOLD.
    - Otherwise: pulse err with code 0 and go to IDLE.
  - HOLD: msg_valid=1. msg_ack goes to IDLE and clears msg_valid on the same edge.
  - DISCARD: drop every byte. Return to IDLE after BYTE_TIMEOUT cycles with no accepted byte. No timeout error is raised here.
- Overrun: a byte accepted in HOLD pulses err with code 3. The held frame is kept intact; the FSM moves to DISCARD when msg_ack arrives, otherwise stays in HOLD and continues dropping bytes.
- Timeout:
  - The counter resets on every accepted byte and counts in PAYLOAD, CRC_HI and CRC_LO.
  - On reaching BYTE_TIMEOUT-1: pulse err with code 1, go to IDLE, discard the partial frame, reset the CRC to 0xFFFF.
- The CRC and idx are reinitialised (0xFFFF, 0) on every IDLE→header transition.
- msg_type and msg_len are latched at the header and are stable through HOLD.
- Buffer: 32×8, single write port (FSM) and single registered read port (consumer). Reads outside HOLD return unspecified data.
- Reset: every state register, the d_rdy edge register and the counters are cleared.
  - Output reset values: msg_valid=0, msg_type=0, msg_len=0, err=0, err_code=0, rd_q=0.
  - Buffer contents are not reset.
  - Asserting rst mid-frame or in HOLD drops the frame, goes to IDLE, and raises no error.

## Timing
- Byte acceptance: at the first edge where d_rdy=1 and its previous sample was 0. A level held high for many cycles accepts exactly one byte.
- msg_valid and CRC err rise at the edge after the edge that accepts the CRC low byte: latency 1 cycle.
- msg_ack sampled at edge k: msg_valid=0 after edge k. A byte whose rising edge is also at edge k is taken as overrun; msg_ack does not yield same-cycle acceptance.
- err is exactly one cycle wide. At most one error per cycle. Priority: overrun > timeout > bad type > CRC. These are mutually exclusive by state.
- A timeout and an accepted byte at the same edge: the byte wins and the counter resets.
- rd_q is valid one cycle after rd_addr.
- Back-to-back bytes: bytes one cycle apart cannot occur, since each needs d_rdy to go low and high again. Minimum byte spacing is 2 cycles, and all states sustain it.

## Test plan
- Good frame: header 0x29, payload "123456789" (0x31..0x39), CRC 0x29 0xB1. Required: msg_valid=1 one cycle after the last byte, msg_type=1, msg_len=9, rd_addr 0..8 reads 0x31..0x39 with 1-cycle latency. msg_ack then clears msg_valid.
- Bad CRC: same frame with CRC 0x29 0xB0. Required: err=1 with err_code=0 one cycle after the last byte, msg_valid stays 0, FSM back in IDLE.
- Zero length: header 0x40 (type 2, N=0), CRC 0xFF 0xFF. Required: msg_valid=1, msg_type=2, msg_len=0.
- Timeout: header 0x29 plus 3 payload bytes, then silence. Required: err with err_code=1 exactly BYTE_TIMEOUT cycles after the last byte; a subsequent good frame is accepted.
- Bad type plus overrun:
  - Header 0xE3: err with code 2; the next 5 bytes are dropped; the FSM returns to IDLE after BYTE_TIMEOUT idle cycles.
  - Good frame held without ack, then one extra byte: err with code 3, held data unchanged.
- Reset mid-frame: rst high for 1 cycle after 4 payload bytes. Required: all outputs at reset values, no err; the next good frame passes.
